// File: rtl/gnrc_downsizer_if.sv
// Stream interface for gnrc_downsizer: wide ready/valid input side, narrow ready/valid
// output side, and a flush strobe. Signal names keep the block's own port naming.
interface gnrc_downsizer_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned RATIO = 4,
    parameter int unsigned CW    = $clog2(RATIO)
);
    logic                  flush_i;
    logic                  valid_i;
    logic [RATIO*DW-1:0]   data_i;
    logic [CW-1:0]         nbeat_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DW-1:0]         data_o;
    logic                  last_o;
    logic                  ready_i;

    // Downsizer side
    modport slave (
        input  flush_i, valid_i, data_i, nbeat_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    // Environment side (source of wide words, sink of narrow beats)
    modport master (
        output flush_i, valid_i, data_i, nbeat_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/gnrc_downsizer.sv
// Stream width converter: one RATIO*DW-bit word in, up to RATIO DW-bit beats out.
// Output side is fully registered; ready_o depends on ready_i only via last_o.
module gnrc_downsizer #(
    parameter int unsigned DW        = 8,
    parameter int unsigned RATIO     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gnrc_downsizer_if.slave   bus
);
    localparam int unsigned   CW      = $clog2(RATIO);
    localparam logic [CW-1:0] LastIdx = CW'(RATIO - 1);

    logic                         valid_q, valid_d;
    logic [RATIO*DW-1:0]          data_q, data_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [CW-1:0]                nb_q, nb_d;

    logic [RATIO-1:0][DW-1:0]     lanes;
    logic [CW-1:0]                lane;
    logic                         last;
    logic                         ready;
    logic                         accept;
    logic                         out_hs;

    assign lanes  = data_q;
    assign lane   = MSB_FIRST ? (LastIdx - cnt_q) : cnt_q;
    assign last   = valid_q & (cnt_q == nb_q);
    assign ready  = ~valid_q | (bus.ready_i & last);
    assign accept = bus.valid_i & ready & ~bus.flush_i;
    assign out_hs = valid_q & bus.ready_i;

    assign bus.valid_o = valid_q;
    assign bus.last_o  = last;
    assign bus.ready_o = ready;
    assign bus.data_o  = lanes[lane];

    // Next state: flush beats accept beats output handshake; accept on the last beat
    // reloads directly so consecutive words have no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.data_i;
            cnt_d   = '0;
            // Clamp only bites when RATIO is not a power of two
            nb_d    = (bus.nbeat_i > LastIdx) ? LastIdx : bus.nbeat_i;
        end else if (out_hs) begin
            if (last) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset clearing everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            nb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
        end
    end
endmodule

// File: tb/tb_gnrc_downsizer.sv
// Directed bench for gnrc_downsizer: LSB-first instance (bus0) and MSB-first instance (bus1).
module tb_gnrc_downsizer;
    localparam int unsigned DW    = 8;
    localparam int unsigned RATIO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gnrc_downsizer_if #(.DW(DW), .RATIO(RATIO)) bus0 ();
    gnrc_downsizer_if #(.DW(DW), .RATIO(RATIO)) bus1 ();

    gnrc_downsizer #(.DW(DW), .RATIO(RATIO), .MSB_FIRST(1'b0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    gnrc_downsizer #(.DW(DW), .RATIO(RATIO), .MSB_FIRST(1'b1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check the beat presented by bus0, then advance one cycle
    task automatic beat0(input string tag, input logic [7:0] d, input logic l, input logic r);
        check_eq({tag, "_valid"}, 32'(bus0.valid_o), 32'd1);
        check_eq({tag, "_data"},  32'(bus0.data_o),  32'(d));
        check_eq({tag, "_last"},  32'(bus0.last_o),  32'(l));
        check_eq({tag, "_ready"}, 32'(bus0.ready_o), 32'(r));
        step();
    endtask

    task automatic idle0(input string tag);
        check_eq({tag, "_valid"}, 32'(bus0.valid_o), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus0.ready_o), 32'd1);
    endtask

    initial begin
        bus0.flush_i = 1'b0; bus0.valid_i = 1'b0; bus0.data_i = '0;
        bus0.nbeat_i = '0;   bus0.ready_i = 1'b0;
        bus1.flush_i = 1'b0; bus1.valid_i = 1'b0; bus1.data_i = '0;
        bus1.nbeat_i = '0;   bus1.ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        step();
        check_eq("rst_valid", 32'(bus0.valid_o), 32'd0);
        check_eq("rst_last",  32'(bus0.last_o),  32'd0);
        check_eq("rst_data",  32'(bus0.data_o),  32'd0);
        check_eq("rst_ready", 32'(bus0.ready_o), 32'd1);
        check_eq("rst1_ready", 32'(bus1.ready_o), 32'd1);
        rst = 1'b0;

        // Full word, LSB first
        bus0.ready_i = 1'b1;
        bus0.valid_i = 1'b1; bus0.data_i = 32'h4433_2211; bus0.nbeat_i = 2'd3;
        step();
        bus0.valid_i = 1'b0;
        beat0("full0", 8'h11, 1'b0, 1'b0);
        beat0("full1", 8'h22, 1'b0, 1'b0);
        beat0("full2", 8'h33, 1'b0, 1'b0);
        beat0("full3", 8'h44, 1'b1, 1'b1);
        idle0("full_end");

        // Back-to-back words, second offered while the first drains
        bus0.valid_i = 1'b1; bus0.data_i = 32'hDDCC_BBAA; bus0.nbeat_i = 2'd3;
        step();
        bus0.data_i = 32'h4433_2211;
        beat0("b2b0", 8'hAA, 1'b0, 1'b0);
        beat0("b2b1", 8'hBB, 1'b0, 1'b0);
        beat0("b2b2", 8'hCC, 1'b0, 1'b0);
        beat0("b2b3", 8'hDD, 1'b1, 1'b1);
        bus0.valid_i = 1'b0;
        beat0("b2b4", 8'h11, 1'b0, 1'b0);
        beat0("b2b5", 8'h22, 1'b0, 1'b0);
        beat0("b2b6", 8'h33, 1'b0, 1'b0);
        beat0("b2b7", 8'h44, 1'b1, 1'b1);
        idle0("b2b_end");

        // Partial word, MSB first
        bus1.ready_i = 1'b1;
        bus1.valid_i = 1'b1; bus1.data_i = 32'h4433_2211; bus1.nbeat_i = 2'd1;
        step();
        bus1.valid_i = 1'b0;
        check_eq("msb0_valid", 32'(bus1.valid_o), 32'd1);
        check_eq("msb0_data",  32'(bus1.data_o),  32'h44);
        check_eq("msb0_last",  32'(bus1.last_o),  32'd0);
        check_eq("msb0_ready", 32'(bus1.ready_o), 32'd0);
        step();
        check_eq("msb1_data",  32'(bus1.data_o),  32'h33);
        check_eq("msb1_last",  32'(bus1.last_o),  32'd1);
        check_eq("msb1_ready", 32'(bus1.ready_o), 32'd1);
        step();
        check_eq("msb_end_valid", 32'(bus1.valid_o), 32'd0);
        check_eq("msb_end_ready", 32'(bus1.ready_o), 32'd1);

        // Backpressure: ready_i 1,0,0,1,1,1 across the beats
        bus0.valid_i = 1'b1; bus0.data_i = 32'h4433_2211; bus0.nbeat_i = 2'd3;
        step();
        bus0.valid_i = 1'b0;
        bus0.ready_i = 1'b1; beat0("bp0", 8'h11, 1'b0, 1'b0);
        bus0.ready_i = 1'b0; beat0("bp1", 8'h22, 1'b0, 1'b0);
        bus0.ready_i = 1'b0; beat0("bp2", 8'h22, 1'b0, 1'b0);
        bus0.ready_i = 1'b1; beat0("bp3", 8'h22, 1'b0, 1'b0);
        bus0.ready_i = 1'b1; beat0("bp4", 8'h33, 1'b0, 1'b0);
        bus0.ready_i = 1'b1; beat0("bp5", 8'h44, 1'b1, 1'b1);
        idle0("bp_end");

        // Flush after the first beat; data_q survives so lane 0 is still visible
        bus0.valid_i = 1'b1; bus0.data_i = 32'h4433_2211; bus0.nbeat_i = 2'd3;
        step();
        bus0.valid_i = 1'b0;
        beat0("fl0", 8'h11, 1'b0, 1'b0);
        bus0.flush_i = 1'b1;
        step();
        idle0("fl_after");
        check_eq("fl_data_kept", 32'(bus0.data_o), 32'h11);
        // An input handshake during flush is discarded
        bus0.valid_i = 1'b1; bus0.data_i = 32'h8877_6655;
        step();
        idle0("fl_discard");
        check_eq("fl_discard_data", 32'(bus0.data_o), 32'h11);
        bus0.flush_i = 1'b0;
        step();
        bus0.valid_i = 1'b0;
        beat0("nw0", 8'h55, 1'b0, 1'b0);

        // Reset in the middle of a word
        check_eq("pre_rst_data", 32'(bus0.data_o), 32'h66);
        rst = 1'b1;
        step();
        check_eq("mrst_valid", 32'(bus0.valid_o), 32'd0);
        check_eq("mrst_last",  32'(bus0.last_o),  32'd0);
        check_eq("mrst_data",  32'(bus0.data_o),  32'd0);
        check_eq("mrst_ready", 32'(bus0.ready_o), 32'd1);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gnrc_downsizer.md
Name: gnrc_downsizer

Overview:
- Stream width converter. Accepts one wide word of RATIO*DW lanes on a ready/valid input and emits it as up to RATIO narrow DW-bit beats on a ready/valid output.
- Sits directly upstream of gnrc_slice on narrow datapaths, for example bus-to-byte serialisation ahead of a pipelined narrow link.
- Output side is fully registered. The input ready depends combinationally on the output ready only on the final beat.
- A per-word beat count allows partial words, and last_o marks the final beat of each word.

Parameters:
DW, 8, narrow output beat width in bits (>=1)
RATIO, 4, number of DW lanes in one input word (>=2)
MSB_FIRST, 0, 0 = lane 0 (bits DW-1:0) emitted first; 1 = lane RATIO-1 emitted first
CW, $clog2(RATIO), derived width of beat counter; not to be overridden

Ports:
clk_i  input  1  clock, positive edge triggered
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  synchronous clear of buffered word; acts like reset except it does not clear data_q
valid_i  input  1  input word valid
data_i  input  RATIO*DW  input wide word
nbeat_i  input  CW  number of beats to emit minus 1 (0 = one beat)
ready_o  output  1  block can accept an input word this cycle
valid_o  output  1  output beat valid
data_o  output  DW  output beat
last_o  output  1  current output beat is the last beat of its word
ready_i  input  1  downstream ready

Behaviour:
- State registers:
  - valid_q: word held, which also serves as the IDLE/SEND state.
  - data_q.
  - cnt_q: current beat index.
  - nb_q: latched nbeat.
- Reset (rst_i=1 at clock edge) clears all state to 0:
  - valid_q=0, data_q=0, cnt_q=0, nb_q=0.
  - Outputs: valid_o=0, last_o=0, data_o=0, ready_o=1.
  - Reset has priority over flush_i and over any handshake in the same cycle.
- Outputs:
  - valid_o = valid_q.
  - last_o = valid_q & (cnt_q == nb_q).
  - ready_o = ~valid_q | (ready_i & last_o).
- Beat selection:
  - data_o = lane L of data_q, i.e. bits L*DW+DW-1 down to L*DW.
  - L = cnt_q when MSB_FIRST=0; L = RATIO-1-cnt_q when MSB_FIRST=1.
- Accept: valid_i & ready_o & ~flush_i. On accept:
  - data_q <= data_i, cnt_q <= 0, valid_q <= 1.
  - nb_q <= min(nbeat_i, RATIO-1). Clamping only matters when RATIO is not a power of two.
- Output handshake: valid_o & ready_i.
  - Not last beat: cnt_q <= cnt_q+1.
  - Last beat, no simultaneous accept: valid_q <= 0, cnt_q <= 0.
  - Last beat with simultaneous accept: the new word loads. No bubble between words.
- Latency and throughput:
  - First beat of an accepted word is presented on valid_o the cycle after acceptance.
  - Sustained throughput is nb+1 cycles per word with ready_i held high, where nb is the latched beat count (nb_q).
- Stability: while valid_o & ~ready_i, data_o, last_o and valid_o hold constant.
- flush_i (and rst_i=0):
  - valid_q <= 0, cnt_q <= 0. data_q is untouched.
  - An in-flight input handshake in the flush cycle is discarded.
  - flush_i has no effect on the combinational path: ready_o is still computed as above.
  - Flush has priority over a simultaneous output handshake.
- Reset or flush in the middle of a word: the remaining beats are dropped. The next accepted word starts at beat 0.
- Timing note: the ready_i-to-ready_o path exists only through last_o. Where a registered backward path is required, place gnrc_slice with BACKWARD_Q=1 upstream.

Test Plan:
- Full word: DW=8, RATIO=4, MSB_FIRST=0, data_i=0x44332211, nbeat_i=3, ready_i=1 -> data_o 0x11,0x22,0x33,0x44 in consecutive cycles. last_o=1 only on 0x44. ready_o=0 on beats 0-2.
- Back-to-back: two words 0xDDCCBBAA then 0x44332211 offered continuously with ready_i=1 -> 8 consecutive beats with no gap. Second word accepted in the same cycle that 0xDD is consumed.
- Partial word and MSB_FIRST=1: data_i=0x44332211, nbeat_i=1 -> beats 0x44,0x33. last_o on 0x33. ready_o=1 the cycle after 0x33 is consumed.
- Backpressure: ready_i toggles 1,0,0,1,1,1 during a full word -> data_o holds 0x22 across both stall cycles. Exactly 4 beats, no duplication, no loss.
- Flush and reset mid-word:
  - flush_i pulsed after beat 0x11 is consumed -> valid_o=0 the next cycle.
  - Next word 0x88776655 starts at 0x55.
  - rst_i asserted mid-word -> valid_o=0, last_o=0, data_o=0, ready_o=1.
